// File: rtl/of_stage_pkg.sv
// Shared RV32I decode definitions for the operand-fetch stage and its
// downstream consumers: opcodes, control-bundle layout, ALU op encodings and
// the immediate generator.
package of_stage_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Control bundle width and bit positions
  localparam int CTRL_W        = 12;
  localparam int CTRL_IS_LOAD  = 0;
  localparam int CTRL_IS_STORE = 1;
  localparam int CTRL_IS_BR    = 2;
  localparam int CTRL_IS_JAL   = 3;
  localparam int CTRL_IS_JALR  = 4;
  localparam int CTRL_IS_LUI   = 5;
  localparam int CTRL_IS_AUIPC = 6;
  localparam int CTRL_USE_IMM  = 7;
  localparam int CTRL_WB_EN    = 8;
  localparam int CTRL_ILLEGAL  = 9;
  localparam int CTRL_ALU_LSB  = 10;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b01;
  localparam logic [1:0] ALU_CMP   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  // Packed view of the control bundle; field order matches the bit positions above
  typedef struct packed {
    logic [1:0] alu_op;
    logic       illegal;
    logic       wb_en;
    logic       use_imm;
    logic       is_auipc;
    logic       is_lui;
    logic       is_jalr;
    logic       is_jal;
    logic       is_branch;
    logic       is_store;
    logic       is_load;
  } ctrl_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  // Sign-extended immediate in byte units for the given instruction format
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/of_stage_register_file.sv
// Architectural register file: x0 reads as zero, two asynchronous read ports,
// one synchronous write port with write-through to both read ports.
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_rs1,
  input  logic [AW-1:0]   i_rs2,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [0:NREG-1];

  // Storage update: clear on reset, writes to x0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (i_we && (i_rd != {AW{1'b0}})) begin
      r_regs[i_rd] <= i_wd;
    end
  end

  // Read port 1: x0 is zero, a same-cycle write to the source forwards its data
  always_comb begin
    if (i_rs1 == {AW{1'b0}}) begin
      o_rs1_data = {XLEN{1'b0}};
    end else if (i_we && (i_rd == i_rs1)) begin
      o_rs1_data = i_wd;
    end else begin
      o_rs1_data = r_regs[i_rs1];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    if (i_rs2 == {AW{1'b0}}) begin
      o_rs2_data = {XLEN{1'b0}};
    end else if (i_we && (i_rd == i_rs2)) begin
      o_rs2_data = i_wd;
    end else begin
      o_rs2_data = r_regs[i_rs2];
    end
  end

endmodule

// File: rtl/of_stage.sv
// RV32I operand-fetch stage: decode, register read, immediate generation,
// load-use hazard detection and the OF/EX pipeline register.
module of_stage
  import of_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   IF_OF_PC,
  input  logic [31:0]       IF_OF_INST,
  input  logic              isBranchtaken,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              of_stall,
  output logic              OF_EX_VALID,
  output logic [XLEN-1:0]   OF_EX_PC,
  output logic [31:0]       OF_EX_INST,
  output logic [XLEN-1:0]   OF_EX_A,
  output logic [XLEN-1:0]   OF_EX_B,
  output logic [XLEN-1:0]   OF_EX_IMM,
  output logic [4:0]        OF_EX_RD,
  output logic [CTRL_W-1:0] OF_EX_CTRL
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  ctrl_t           w_ctrl;
  imm_fmt_e        w_fmt;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic [4:0]      w_rd;
  logic [31:0]     w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_bubble;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;

  assign w_opcode = IF_OF_INST[6:0];
  assign w_rs1    = IF_OF_INST[19:15];
  assign w_rs2    = IF_OF_INST[24:20];

  register_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_register_file (
    .clk        (clk),
    .rst        (rst),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (wb_en),
    .i_rd       (wb_rd),
    .i_wd       (wb_data)
  );

  // Main decoder: control bundle, immediate format and which sources are read
  always_comb begin
    w_ctrl    = '0;
    w_fmt     = FMT_R;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.is_lui  = 1'b1;
        w_ctrl.use_imm = 1'b1;
        w_ctrl.wb_en   = 1'b1;
        w_ctrl.alu_op  = ALU_PASSB;
        w_fmt          = FMT_U;
      end
      OPC_AUIPC: begin
        w_ctrl.is_auipc = 1'b1;
        w_ctrl.use_imm  = 1'b1;
        w_ctrl.wb_en    = 1'b1;
        w_ctrl.alu_op   = ALU_ADD;
        w_fmt           = FMT_U;
      end
      OPC_JAL: begin
        w_ctrl.is_jal  = 1'b1;
        w_ctrl.use_imm = 1'b1;
        w_ctrl.wb_en   = 1'b1;
        w_ctrl.alu_op  = ALU_ADD;
        w_fmt          = FMT_J;
      end
      OPC_JALR: begin
        w_ctrl.is_jalr = 1'b1;
        w_ctrl.use_imm = 1'b1;
        w_ctrl.wb_en   = 1'b1;
        w_ctrl.alu_op  = ALU_ADD;
        w_fmt          = FMT_I;
        w_use_rs1      = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.is_branch = 1'b1;
        w_ctrl.alu_op    = ALU_CMP;
        w_fmt            = FMT_B;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      OPC_LOAD: begin
        w_ctrl.is_load = 1'b1;
        w_ctrl.use_imm = 1'b1;
        w_ctrl.wb_en   = 1'b1;
        w_ctrl.alu_op  = ALU_ADD;
        w_fmt          = FMT_I;
        w_use_rs1      = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.is_store = 1'b1;
        w_ctrl.use_imm  = 1'b1;
        w_ctrl.alu_op   = ALU_ADD;
        w_fmt           = FMT_S;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctrl.use_imm = 1'b1;
        w_ctrl.wb_en   = 1'b1;
        w_ctrl.alu_op  = ALU_FUNCT;
        w_fmt          = FMT_I;
        w_use_rs1      = 1'b1;
      end
      OPC_OP: begin
        w_ctrl.wb_en  = 1'b1;
        w_ctrl.alu_op = ALU_FUNCT;
        w_fmt         = FMT_R;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      default: begin
        w_ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Destination is reported only for instructions that write back
  assign w_rd  = w_ctrl.wb_en ? IF_OF_INST[11:7] : 5'd0;
  assign w_imm = imm_gen(IF_OF_INST, w_fmt);

  // Load in OF/EX whose destination feeds a source the current instruction reads
  assign w_hazard = r_valid && r_ctrl[CTRL_IS_LOAD] && (r_rd != 5'd0) &&
                    ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));

  // A redirect discards this instruction, so it must never hold fetch
  assign of_stall = w_hazard && !isBranchtaken;
  assign w_bubble = w_hazard || isBranchtaken;

  // OF/EX pipeline register: bubble on flush or load-use, otherwise capture decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= {XLEN{1'b0}};
      r_inst  <= 32'h0000_0000;
      r_a     <= {XLEN{1'b0}};
      r_b     <= {XLEN{1'b0}};
      r_imm   <= {XLEN{1'b0}};
      r_rd    <= 5'd0;
      r_ctrl  <= {CTRL_W{1'b0}};
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= {XLEN{1'b0}};
      r_inst  <= 32'h0000_0000;
      r_a     <= {XLEN{1'b0}};
      r_b     <= {XLEN{1'b0}};
      r_imm   <= {XLEN{1'b0}};
      r_rd    <= 5'd0;
      r_ctrl  <= {CTRL_W{1'b0}};
    end else begin
      r_valid <= 1'b1;
      r_pc    <= IF_OF_PC;
      r_inst  <= IF_OF_INST;
      r_a     <= w_rs1_data;
      r_b     <= w_rs2_data;
      r_imm   <= w_imm;
      r_rd    <= w_rd;
      r_ctrl  <= w_ctrl;
    end
  end

  assign OF_EX_VALID = r_valid;
  assign OF_EX_PC    = r_pc;
  assign OF_EX_INST  = r_inst;
  assign OF_EX_A     = r_a;
  assign OF_EX_B     = r_b;
  assign OF_EX_IMM   = r_imm;
  assign OF_EX_RD    = r_rd;
  assign OF_EX_CTRL  = r_ctrl;

endmodule
